// File: rtl/memtile_cfg_loader.sv
// Config-bus initiator for a LakeTop memtile: streams (addr,data) words into the
// tile's config port, optionally reads each back and compares, then flushes and enables.
module memtile_cfg_loader #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 32,
    parameter int VERIFY       = 1,
    parameter int RD_LAT       = 1,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              cfg_last,
    input  logic              restart,
    output logic              config_en,
    output logic              config_write,
    output logic              config_read,
    output logic [ADDR_W-1:0] config_addr_in,
    output logic [DATA_W-1:0] config_data_in,
    input  logic [DATA_W-1:0] config_data_out,
    output logic              flush,
    output logic              tile_en,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] err_addr
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_FLUSH = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int FL_W   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((RD_LAT > 1) ? (RD_LAT - 2) : 0);
    localparam logic [FL_W-1:0]   FL_LAST   = FL_W'(FLUSH_CYCLES - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [FL_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic              error_q, error_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;

    logic              config_en_q, config_write_q, config_read_q;
    logic [ADDR_W-1:0] config_addr_q;
    logic [DATA_W-1:0] config_wdata_q;
    logic              flush_q, done_q, tile_en_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        last_d      = last_q;
        wait_cnt_d  = wait_cnt_q;
        flush_cnt_d = flush_cnt_q;
        error_d     = error_q;
        err_addr_d  = err_addr_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    addr_d  = cfg_addr;
                    data_d  = cfg_data;
                    last_d  = cfg_last;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (VERIFY != 0) begin
                    state_d = S_READ;
                end else if (last_q) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                wait_cnt_d = '0;
                state_d    = (RD_LAT > 1) ? S_WAIT : S_CHECK;
            end
            S_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                // A mismatch is recorded but never aborts the program; first address wins.
                if (config_data_out != data_q) begin
                    error_d = 1'b1;
                    if (!error_q) begin
                        err_addr_d = addr_q;
                    end
                end
                if (last_q) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (flush_cnt_q == FL_LAST) begin
                    state_d = S_DONE;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (restart) begin
                    state_d    = S_IDLE;
                    error_d    = 1'b0;
                    err_addr_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            last_q      <= 1'b0;
            wait_cnt_q  <= '0;
            flush_cnt_q <= '0;
            error_q     <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            last_q      <= last_d;
            wait_cnt_q  <= wait_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            error_q     <= error_d;
            err_addr_q  <= err_addr_d;
        end
    end

    // Bus outputs are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            config_en_q    <= 1'b0;
            config_write_q <= 1'b0;
            config_read_q  <= 1'b0;
            config_addr_q  <= '0;
            config_wdata_q <= '0;
            flush_q        <= 1'b0;
            done_q         <= 1'b0;
            tile_en_q      <= 1'b0;
        end else begin
            config_en_q    <= (state_d == S_WRITE) || (state_d == S_READ);
            config_write_q <= (state_d == S_WRITE);
            config_read_q  <= (state_d == S_READ);
            config_addr_q  <= ((state_d == S_WRITE) || (state_d == S_READ)) ? addr_d : '0;
            config_wdata_q <= (state_d == S_WRITE) ? data_d : '0;
            flush_q        <= (state_d == S_FLUSH);
            done_q         <= (state_d == S_DONE);
            tile_en_q      <= (state_d == S_DONE);
        end
    end

    assign cfg_ready      = (state_q == S_IDLE);
    assign config_en      = config_en_q;
    assign config_write   = config_write_q;
    assign config_read    = config_read_q;
    assign config_addr_in = config_addr_q;
    assign config_data_in = config_wdata_q;
    assign flush          = flush_q;
    assign done           = done_q;
    assign tile_en        = tile_en_q;
    assign error          = error_q;
    assign err_addr       = err_addr_q;

endmodule
